// File: rtl/alu_pipe_unit.sv
// Registered, valid/ready handshaked ALU with carry/overflow/illegal flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (opcode 1010).
module alu_pipe_unit #(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_lt,
  output logic             out_gt,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic             busy,
  output logic             dbg_state_o
);

  localparam int SH = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_SLT  = 4'h8;
  localparam logic [3:0] OP_SLTU = 4'h9;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'hA;
`endif

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;
  state_t state_q, state_d;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d, lt_q, lt_d, gt_q, gt_d;
  logic             carry_q, carry_d, ovf_q, ovf_d, illegal_q, illegal_d;

  logic             accept;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SH-1:0]    shamt;
  logic             a_lt_b_s, a_lt_b_u, cmp_lt, cmp_gt, sum_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_ovf, alu_illegal;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, mul_sum;
  logic [SH-1:0]    cnt_q, cnt_d;
  logic             mlt_q, mlt_d, mgt_q, mgt_d;
`endif

  assign in_ready    = rst_n && (state_q == ST_IDLE) && (!valid_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign out_valid   = valid_q;
  assign out_result  = res_q;
  assign out_zero    = zero_q;
  assign out_lt      = lt_q;
  assign out_gt      = gt_q;
  assign out_carry   = carry_q;
  assign out_ovf     = ovf_q;
  assign out_illegal = illegal_q;
  assign dbg_state_o = state_q;
`ifdef ALU_MUL_EN
  assign busy    = (state_q == ST_MUL);
  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
`else
  assign busy = 1'b0;
`endif

  // SUB shares the adder: A + ~B + 1, so borrow is the inverted carry-out.
  always_comb begin
    is_sub   = (in_op == OP_SUB);
    b_eff    = is_sub ? ~in_b : in_b;
    sum      = {1'b0, in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    sum_ovf  = (in_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
    shamt    = in_b[SH-1:0];
    a_lt_b_s = $signed(in_a) < $signed(in_b);
    a_lt_b_u = in_a < in_b;
    cmp_lt   = SIGNED_CMP ? a_lt_b_s : a_lt_b_u;
    cmp_gt   = SIGNED_CMP ? ($signed(in_a) > $signed(in_b)) : (in_a > in_b);

    alu_res     = sum[WIDTH-1:0];
    alu_carry   = 1'b0;
    alu_ovf     = 1'b0;
    alu_illegal = 1'b0;
    case (in_op)
      OP_ADD:  begin alu_carry = sum[WIDTH]; alu_ovf = sum_ovf; end
      OP_SUB:  begin alu_carry = ~sum[WIDTH]; alu_ovf = sum_ovf; end
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SLL:  alu_res = in_a << shamt;
      OP_SRL:  alu_res = in_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(in_a) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, a_lt_b_s};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a_lt_b_u};
`ifdef ALU_MUL_EN
      OP_MUL:  alu_res = sum[WIDTH-1:0];
`endif
      default: begin alu_carry = sum[WIDTH]; alu_ovf = sum_ovf; alu_illegal = 1'b1; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    res_d     = res_q;
    zero_d    = zero_q;
    lt_d      = lt_q;
    gt_d      = gt_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    illegal_d = illegal_q;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mlt_d    = mlt_q;
    mgt_d    = mgt_q;
`endif
    if (valid_q && out_ready) valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef ALU_MUL_EN
          if (in_op == OP_MUL) begin
            state_d  = ST_MUL;
            mcand_d  = in_a;
            mplier_d = in_b;
            acc_d    = '0;
            cnt_d    = '0;
            mlt_d    = cmp_lt;
            mgt_d    = cmp_gt;
          end else
`endif
          begin
            valid_d   = 1'b1;
            res_d     = alu_res;
            zero_d    = (alu_res == '0);
            lt_d      = cmp_lt;
            gt_d      = cmp_gt;
            carry_d   = alu_carry;
            ovf_d     = alu_ovf;
            illegal_d = alu_illegal;
          end
        end
      end
      ST_MUL: begin
`ifdef ALU_MUL_EN
        // The last step writes its partial sum straight to the output register.
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SH'(WIDTH-1)) begin
          state_d   = ST_IDLE;
          valid_d   = 1'b1;
          res_d     = mul_sum;
          zero_d    = (mul_sum == '0);
          lt_d      = mlt_q;
          gt_d      = mgt_q;
          carry_d   = 1'b0;
          ovf_d     = 1'b0;
          illegal_d = 1'b0;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      lt_q      <= 1'b0;
      gt_q      <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mlt_q    <= 1'b0;
      mgt_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      lt_q      <= lt_d;
      gt_q      <= gt_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mlt_q    <= mlt_d;
      mgt_q    <= mgt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe_unit.sv
// Bench for alu_pipe_unit (WIDTH=32); directed and random ops against an arithmetic model.
// Define ALU_MUL_EN here as for the RTL to exercise the multiplier build.
module tb_alu_pipe_unit;
  localparam int WIDTH = 32;
  localparam bit SCMP  = 1'b0;
  localparam int EW    = WIDTH + 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_op = 4'h0;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_result;
  logic             out_zero, out_lt, out_gt, out_carry, out_ovf, out_illegal, busy;
  logic             dbg_state;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  alu_pipe_unit #(.WIDTH(WIDTH), .SIGNED_CMP(SCMP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_lt(out_lt), .out_gt(out_gt),
    .out_carry(out_carry), .out_ovf(out_ovf), .out_illegal(out_illegal), .busy(busy),
    .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: {illegal, ovf, carry, gt, lt, zero, result}
  function automatic logic [EW-1:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub, s, maxv, minv;
    logic [31:0] r;
    logic c, v, ill, lt, gt;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    maxv = 2147483647;
    minv = -maxv - 1;
    c = 1'b0; v = 1'b0; ill = 1'b0;
    case (op)
      4'h1: begin r = a - b; c = (a < b); s = sa - sb; v = (s > maxv) || (s < minv); end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = a << (b % 32);
      4'h6: r = a >> (b % 32);
      4'h7: r = $unsigned($signed(a) >>> (b % 32));
      4'h8: r = (sa < sb) ? 32'd1 : 32'd0;
      4'h9: r = (ua < ub) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
      4'hA: r = a * b;
`endif
      default: begin
        r = a + b;
        c = (ua + ub) > 64'hFFFF_FFFF;
        s = sa + sb;
        v = (s > maxv) || (s < minv);
        ill = (op != 4'h0);
      end
    endcase
    lt = SCMP ? (sa < sb) : (ua < ub);
    gt = SCMP ? (sa > sb) : (ua > ub);
    return {ill, v, c, gt, lt, (r == 32'd0), r};
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // scoreboard: push on accept, pop on output transfer, check hold while stalled
  logic          hold_prev = 1'b0;
  logic [EW:0]   snap_prev = '0;
  logic [EW-1:0] exp_v;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev)
        check("hold_stable", {out_valid, out_illegal, out_ovf, out_carry, out_gt, out_lt,
                              out_zero, out_result}, snap_prev);
      if (out_valid && !out_ready) check("hold_in_ready", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_spurious", out_valid, 1'b0);
        else begin
          exp_v = exp_q.pop_front();
          check("sb_result", {out_illegal, out_ovf, out_carry, out_gt, out_lt, out_zero,
                              out_result}, exp_v);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_op, in_a, in_b));
      hold_prev = out_valid && !out_ready;
      snap_prev = {out_valid, out_illegal, out_ovf, out_carry, out_gt, out_lt, out_zero,
                   out_result};
    end
  end

  // driver tasks; all return #1 after a rising edge
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && n < 200) begin tick(1); n++; end
    if (n >= 200) check("issue_timeout", in_ready, 1'b1);
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while ((out_valid || busy) && n < 100) begin tick(1); n++; end
    check("drain", {out_valid, busy}, 2'b00);
  endtask

  initial begin
    int accepted = 0;
    int guard = 0;
    logic fire;
    logic saw_valid;

    // reset
    tick(3);
    check("rst_outputs", {out_valid, out_illegal, out_ovf, out_carry, out_gt, out_lt,
                          out_zero, out_result}, '0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    tick(1);

    // directed vectors, out_ready=1
    issue(4'h0, 32'hFFFF_FFFF, 32'h1);
    check("add_valid", out_valid, 1'b1);
    check("add_res", out_result, 32'h0);
    check("add_flags", {out_zero, out_carry, out_ovf, out_gt, out_lt}, 5'b11010);

    issue(4'h1, 32'h8000_0000, 32'h1);
    check("sub_res", out_result, 32'h7FFF_FFFF);
    check("sub_flags", {out_ovf, out_carry, out_lt, out_gt}, SCMP ? 4'b1010 : 4'b1001);

    issue(4'h7, 32'hF000_0000, 32'd36);
    check("sra_res", out_result, 32'hFF00_0000);

    issue(4'h9, 32'h1, 32'hFFFF_FFFF);
    check("sltu_res", out_result, 32'h1);

    issue(4'hF, 32'd2, 32'd3);
    check("illegal_res", out_result, 32'd5);
    check("illegal_flag", out_illegal, 1'b1);

`ifndef ALU_MUL_EN
    issue(4'hA, 32'd2, 32'd3);
    check("nomul_res", out_result, 32'd5);
    check("nomul_illegal", out_illegal, 1'b1);
    check("nomul_busy", busy, 1'b0);
    tick(1);
    check("nomul_busy_after", busy, 1'b0);
`endif
    drain();

    // back-to-back ADDs
    in_valid = 1'b1; in_op = 4'h0;
    for (int i = 0; i < 4; i++) begin
      in_a = 32'(i * 7); in_b = 32'(100 + i);
      check("b2b_in_ready", in_ready, 1'b1);
      tick(1);
      check("b2b_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    check("b2b_last_res", out_result, 32'd124);
    tick(1);
    check("b2b_valid_fall", out_valid, 1'b0);

    // stall for 3 cycles with a pending op behind it
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'h0; in_a = 32'd10; in_b = 32'd20;
    tick(1);
    in_op = 4'h4; in_a = 32'h0000_F0F0; in_b = 32'h0000_0FF0;
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_valid", out_valid, 1'b1);
      check("stall_res", out_result, 32'd30);
      tick(1);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1'b1);
    tick(1);
    in_valid = 1'b0;
    check("release_valid", out_valid, 1'b1);
    check("release_res", out_result, 32'h0000_FF00);
    drain();

`ifdef ALU_MUL_EN
    // iterative multiply
    issue(4'hA, 32'h0001_2345, 32'h0000_0100);
    for (int k = 0; k < 32; k++) begin
      check("mul_busy", {busy, in_ready, out_valid}, 3'b100);
      tick(1);
    end
    check("mul_valid", {out_valid, busy}, 2'b10);
    check("mul_res", out_result, 32'h0123_4500);
    check("mul_flags", {out_zero, out_carry, out_ovf, out_gt, out_lt}, 5'b00010);

    // reset during a second multiply
    issue(4'hA, 32'h0000_0003, 32'h0000_0005);
    tick(9);
    check("mul2_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mulrst_outputs", {out_valid, out_illegal, out_ovf, out_carry, out_gt, out_lt,
                             out_zero, out_result}, '0);
    check("mulrst_busy", {busy, in_ready}, 2'b00);
    tick(2);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      saw_valid = saw_valid | out_valid | busy;
      tick(1);
    end
    check("mulrst_no_output", saw_valid, 1'b0);
    check("mulrst_in_ready", in_ready, 1'b1);
`endif

    // random ops with random back-pressure
    in_valid = 1'b0;
    while (accepted < 150 && guard < 20000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_op = 4'($urandom_range(0, 15));
        in_a = rand_opnd();
        in_b = rand_opnd();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      if (fire) begin accepted++; in_valid = 1'b0; end
      guard++;
    end
    check("rand_accepted", accepted, 150);
    drain();
    tick(1);
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
